// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-back data cache.
// Imported by the line array and the cache top.
package dcache_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LINES_DEF  = 8;
    localparam int WORDS_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        FETCH     = 2'b10
    } state_t;

    // Ceiling log2, used for index/offset field widths.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the cache, one line read combinationally.
// Word writes and block fills land on the addressed line at posedge.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = 3,
    parameter int IDX_W  = log2(LINES),
    parameter int OFF_W  = log2(WORDS)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [IDX_W-1:0]         idx,
    output logic                     valid,
    output logic                     dirty,
    output logic [TAG_W-1:0]         tag,
    output logic [DATA_W*WORDS-1:0]  block,
    input  logic                     word_we,
    input  logic [OFF_W-1:0]         word_off,
    input  logic [DATA_W-1:0]        word_data,
    input  logic                     fill_we,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic [DATA_W*WORDS-1:0]  fill_data
);

    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [DATA_W*WORDS-1:0] data_q [LINES];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign block = data_q[idx];

    // Line status: reset invalidates everything; fill makes a clean line.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data payload; left uninitialised, held frozen during reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (fill_we) begin
                tag_q[idx]  <= fill_tag;
                data_q[idx] <= fill_data;
            end else if (word_we) begin
                data_q[idx][int'(word_off)*DATA_W +: DATA_W] <= word_data;
            end
        end
    end

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate data cache: FSM, hit logic, muxing.
// Hits are zero-latency; misses stall while whole blocks move to/from memory.
module dcache_direct_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LINES  = LINES_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             READ,
    input  logic                             WRITE,
    input  logic [ADDR_W-1:0]                ADDRESS,
    input  logic [DATA_W-1:0]                WRITEDATA,
    output logic [DATA_W-1:0]                READDATA,
    output logic                             BUSYWAIT,
    output logic                             MEM_READ,
    output logic                             MEM_WRITE,
    output logic [ADDR_W-log2(WORDS)-1:0]    MEM_ADDRESS,
    output logic [DATA_W*WORDS-1:0]          MEM_WRITEDATA,
    input  logic [DATA_W*WORDS-1:0]          MEM_READDATA,
    input  logic                             MEM_BUSYWAIT
);

    localparam int OFF_W = log2(WORDS);
    localparam int IDX_W = log2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = DATA_W * WORDS;

    state_t state_q;
    state_t state_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [BLK_W-1:0]  line_block;
    logic [DATA_W-1:0] hit_word;
    logic              hit;
    logic              req;
    logic              word_we;
    logic              fill_we;

    assign req_tag  = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx  = ADDRESS[OFF_W +: IDX_W];
    assign req_off  = ADDRESS[OFF_W-1:0];
    assign hit      = line_valid && (line_tag == req_tag);
    assign req      = READ | WRITE;
    assign hit_word = line_block[int'(req_off)*DATA_W +: DATA_W];

    dcache_line_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W)
    ) u_lines (
        .CLK       (CLK),
        .RESET     (RESET),
        .idx       (req_idx),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .block     (line_block),
        .word_we   (word_we),
        .word_off  (req_off),
        .word_data (WRITEDATA),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_data (MEM_READDATA)
    );

    // Controller state register; reset abandons any transfer in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, cpu handshake and memory strobes decoded from state.
    always_comb begin
        state_d       = state_q;
        READDATA      = '0;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        word_we       = 1'b0;
        fill_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RESET && req) begin
                    if (hit) begin
                        if (READ) READDATA = hit_word;
                        else      word_we  = 1'b1;
                    end else begin
                        BUSYWAIT = 1'b1;
                        state_d  = (line_valid && line_dirty) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag, req_idx};
                MEM_WRITEDATA = line_block;
                BUSYWAIT      = RESET;
                if (!MEM_BUSYWAIT) state_d = FETCH;
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {req_tag, req_idx};
                BUSYWAIT    = RESET;
                if (!MEM_BUSYWAIT) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Randomised scoreboard bench for dcache_direct_wb against a flat-memory model.
// Stimulus pushes expected loads and block transfers; a monitor pops them.
module tb_dcache_direct_wb;

    localparam int MLAT = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    dcache_direct_wb dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mtx_t;

    int   checks = 0;
    int   errs = 0;
    int   both_high = 0;
    logic [7:0] rq[$];
    mtx_t       mq[$];

    logic [7:0]  refm [256];
    logic [31:0] bk   [64];
    bit   [7:0]  mv;
    bit   [7:0]  md;
    logic [2:0]  mt [8];
    bit          mem_ready = 1'b0;
    int          mcnt = 0;

    function automatic logic [31:0] blk_init(input logic [5:0] b);
        if (b == 6'd0) return 32'h44332211;
        return (32'(b) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] blk_of(input logic [5:0] b);
        return {refm[{b, 2'd3}], refm[{b, 2'd2}], refm[{b, 2'd1}], refm[{b, 2'd0}]};
    endfunction

    // Memory: busy until the 5th cycle of a strobe, then completes.
    assign MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && mcnt == MLAT - 1);
    assign MEM_READDATA = bk[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) bk[i] <= blk_init(6'(i));
            mem_ready <= 1'b1;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            bk[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
        if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every completed load and block transfer.
    initial begin
        mtx_t m;
        logic [7:0] e;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) both_high++;
            if (!MEM_READ && !MEM_WRITE)
                check("idle_bus", {26'd0, MEM_ADDRESS, MEM_WRITEDATA}, 64'd0);
            if (MEM_READ) check("fetch_wdata", {32'd0, MEM_WRITEDATA}, 64'd0);
            if (RESET) begin
                if (!READ && !WRITE)
                    check("idle_cpu", {55'd0, BUSYWAIT, READDATA}, 64'd0);
                if (READ && !BUSYWAIT) begin
                    if (rq.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL rd_unexpected actual=%0h expected=none", READDATA);
                    end else begin
                        e = rq.pop_front();
                        check("readdata", {56'd0, READDATA}, {56'd0, e});
                    end
                end
                if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
                    if (mq.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL mem_unexpected actual=%0h expected=none", MEM_ADDRESS);
                    end else begin
                        m = mq.pop_front();
                        check("mem_kind", {63'd0, MEM_WRITE}, {63'd0, m.wr});
                        check("mem_addr", {58'd0, MEM_ADDRESS}, {58'd0, m.addr});
                        if (m.wr)
                            check("wb_data", {32'd0, MEM_WRITEDATA}, {32'd0, m.data});
                    end
                end
            end
        end
    end

    task automatic do_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        logic [2:0] ix;
        logic [2:0] tg;
        bit hit;
        int exp_lat;
        int lat;
        ix = a[4:2];
        tg = a[7:5];
        hit = mv[ix] && mt[ix] == tg;
        exp_lat = 0;
        if (!hit) begin
            exp_lat = MLAT + 1;
            if (mv[ix] && md[ix]) begin
                mq.push_back('{1'b1, {mt[ix], ix}, blk_of({mt[ix], ix})});
                exp_lat += MLAT;
            end
            mq.push_back('{1'b0, {tg, ix}, blk_of({tg, ix})});
            mv[ix] = 1'b1;
            mt[ix] = tg;
            md[ix] = 1'b0;
        end
        if (rd) begin
            rq.push_back(refm[a]);
        end else if (wr) begin
            refm[a] = d;
            md[ix] = 1'b1;
        end
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        #1;
        lat = 0;
        while (BUSYWAIT && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        RESET = 1'b0;
        READ = 1'b0;
        WRITE = 1'b0;
        ADDRESS = '0;
        WRITEDATA = '0;
        mv = '0;
        md = '0;
        for (int i = 0; i < 8; i++) mt[i] = '0;
        for (int a = 0; a < 256; a++) begin
            w = blk_init(6'(a >> 2));
            refm[a] = w[(a % 4) * 8 +: 8];
        end
        repeat (3) begin @(posedge CLK); #1; end
        check("rst_cpu", {55'd0, BUSYWAIT, READDATA}, 64'd0);
        check("rst_strobes", {62'd0, MEM_READ, MEM_WRITE}, 64'd0);
        check("rst_bus", {26'd0, MEM_ADDRESS, MEM_WRITEDATA}, 64'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        do_op(1, 0, 8'h00, 8'h00);
        do_op(1, 0, 8'h03, 8'h00);
        do_op(1, 1, 8'h02, 8'h5A);
        do_op(1, 0, 8'h02, 8'h00);
        do_op(1, 0, 8'h21, 8'h00);
        do_op(1, 0, 8'h00, 8'h00);
        do_op(0, 1, 8'h01, 8'hAB);
        do_op(1, 0, 8'h21, 8'h00);

        // Reset while a fetch is in progress.
        READ = 1'b1;
        ADDRESS = 8'h00;
        #1;
        repeat (3) begin @(posedge CLK); #1; end
        check("pre_rst_fetch", {63'd0, MEM_READ}, 64'd1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("midrst_strobes", {62'd0, MEM_READ, MEM_WRITE}, 64'd0);
        check("midrst_cpu", {55'd0, BUSYWAIT, READDATA}, 64'd0);
        READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        mv = '0;
        md = '0;
        for (int a = 0; a < 256; a++) begin
            w = bk[a >> 2];
            refm[a] = w[(a % 4) * 8 +: 8];
        end
        do_op(1, 0, 8'h00, 8'h00);

        for (int i = 0; i < 8; i++)
            do_op(1, 0, {3'd3, 3'(i), 2'($urandom_range(0, 3))}, 8'h00);
        for (int i = 0; i < 8; i++)
            do_op(1, 0, {3'd3, 3'(i), 2'($urandom_range(0, 3))}, 8'h00);

        for (int n = 0; n < 300; n++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            do_op(rd, wr, 8'($urandom_range(0, 255)), 8'($urandom));
        end

        repeat (2) @(posedge CLK);
        #1;
        check("rq_drained", 64'(rq.size()), 64'd0);
        check("mq_drained", 64'(mq.size()), 64'd0);
        check("strobes_exclusive", 64'(both_high), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
